// File: rtl/branch_predictor_pkg.sv
// Shared constants and counter-state encoding for the gshare branch predictor.
package branch_predictor_pkg;

    localparam int PR_IDX_WIDTH  = 8;
    localparam int PR_HIST_WIDTH = 4;
    localparam int PR_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } cnt_state_t;

    localparam logic [1:0] PR_CNT_INIT = CNT_WEAK_NT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, next-state only; the state lives in the caller's table.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_inc,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_cnt;
        if (i_inc) begin
            if (i_cnt != CNT_STRONG_T) o_next = i_cnt + 2'd1;
        end else begin
            if (i_cnt != CNT_STRONG_NT) o_next = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: zero-latency lookup, commit-side training, retired-only global history.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_WIDTH  = PR_IDX_WIDTH,
    parameter int HIST_WIDTH = PR_HIST_WIDTH,
    parameter int STAT_WIDTH = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [PR_ADDR_WIDTH-1:0] if_to_pr_PC,
    output logic                     pr_to_if_pred_br,
    input  logic                     rob_to_pr_ready,
    input  logic [PR_ADDR_WIDTH-1:0] rob_to_pr_PC,
    input  logic                     rob_to_pr_br_taken,
    output logic [STAT_WIDTH-1:0]    pr_stat_branches,
    output logic [STAT_WIDTH-1:0]    pr_stat_miss
);

    localparam int ENTRIES = 2 ** IDX_WIDTH;

    logic [1:0]            r_table [0:ENTRIES-1];
    logic [HIST_WIDTH-1:0] r_ghr;
    logic [STAT_WIDTH-1:0] r_branches;
    logic [STAT_WIDTH-1:0] r_miss;

    logic [IDX_WIDTH-1:0]  w_hist_ext;
    logic [IDX_WIDTH-1:0]  w_lookup_idx;
    logic [IDX_WIDTH-1:0]  w_train_idx;
    logic                  w_train;
    logic [1:0]            w_train_cnt;
    logic [1:0]            w_train_next;
    logic                  w_train_miss;
    logic [HIST_WIDTH-1:0] w_ghr_next;
    logic                  w_unused_pc_bits;

    assign w_hist_ext   = IDX_WIDTH'(r_ghr);
    assign w_lookup_idx = if_to_pr_PC[IDX_WIDTH+1:2] ^ w_hist_ext;
    assign w_train_idx  = rob_to_pr_PC[IDX_WIDTH+1:2] ^ w_hist_ext;

    // Read-before-write: lookups always see the table and history as of the start of the cycle.
    assign pr_to_if_pred_br = r_table[w_lookup_idx][1];

    // Training handshake: rob_to_pr_ready is a one-cycle valid with no back-pressure; it is
    // consumed only when rdy_in is high (and reset is low), otherwise it is dropped. PC/outcome
    // are ignored whenever the strobe is low.
    assign w_train      = rob_to_pr_ready & rdy_in;
    assign w_train_cnt  = r_table[w_train_idx];
    assign w_train_miss = w_train_cnt[1] != rob_to_pr_br_taken;

    sat_counter2 u_sat_counter2 (
        .i_cnt  (w_train_cnt),
        .i_inc  (rob_to_pr_br_taken),
        .o_next (w_train_next)
    );

    generate
        if (HIST_WIDTH == 1) begin : g_hist1
            assign w_ghr_next = rob_to_pr_br_taken;
        end else begin : g_histn
            assign w_ghr_next = {r_ghr[HIST_WIDTH-2:0], rob_to_pr_br_taken};
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= PR_CNT_INIT;
            end
            r_ghr      <= '0;
            r_branches <= '0;
            r_miss     <= '0;
        end else if (w_train) begin
            r_table[w_train_idx] <= w_train_next;
            r_ghr                <= w_ghr_next;
            // Statistics saturate rather than wrap.
            if (r_branches != {STAT_WIDTH{1'b1}}) r_branches <= r_branches + STAT_WIDTH'(1);
            if (w_train_miss && (r_miss != {STAT_WIDTH{1'b1}})) r_miss <= r_miss + STAT_WIDTH'(1);
        end
    end

    assign pr_stat_branches = r_branches;
    assign pr_stat_miss     = r_miss;

    assign w_unused_pc_bits = ^{if_to_pr_PC[PR_ADDR_WIDTH-1:IDX_WIDTH+2], if_to_pr_PC[1:0],
                                rob_to_pr_PC[PR_ADDR_WIDTH-1:IDX_WIDTH+2], rob_to_pr_PC[1:0]};

endmodule
